// File: rtl/conv_viterbi_decoder.sv
// conv_viterbi_decoder: hard-decision K=7 rate-1/2 Viterbi decoder, full-block traceback.
// Optional CONV_VITERBI_METRIC_EN adds the pm_final / pm_final_valid outputs.
module conv_viterbi_decoder #(
   parameter int PM_W  = 13,
   parameter int N_OUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_axis_valid,
   output logic            s_axis_ready,
   input  logic [7:0]      s_axis_data,
   input  logic            s_axis_last,
   input  logic            s_axis_sop,
   input  logic            s_axis_is_parity,
   output logic            m_axis_valid,
   input  logic            m_axis_ready,
   output logic [7:0]      m_axis_data,
   output logic            m_axis_last,
   output logic            m_axis_sop,
   output logic            m_axis_is_parity,
`ifdef CONV_VITERBI_METRIC_EN
   output logic [PM_W-1:0] pm_final,
   output logic            pm_final_valid,
`endif
   output logic            frame_err
);

   localparam int N_BITS = 8 * N_OUT;
   localparam int N_STEP = N_BITS + 6;
   localparam int N_BYTE = 2 * N_OUT + 2;
   localparam int STEP_W = $clog2(N_STEP + 2);
   localparam int BYTE_W = $clog2(N_BYTE);
   localparam int K_W    = $clog2(N_OUT);

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEP - 1);
   localparam logic [STEP_W-1:0] BITS_END  = STEP_W'(N_BITS);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTE - 1);
   localparam logic [K_W-1:0]    K_LAST    = K_W'(N_OUT - 1);
   localparam logic [PM_W-1:0]   PM_INIT   = PM_W'(4095);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACS,
      ST_ACCEPT,
      ST_TB,
      ST_OUT
   } st_t;

   st_t               state_q, state_d;
   logic [STEP_W-1:0] step_q;
   logic [BYTE_W-1:0] byte_q;
   logic [BYTE_W-1:0] byte_idx;
   logic [1:0]        pair_q;
   logic [7:0]        sh_q;
   logic [5:0]        tb_st_q;
   logic [K_W-1:0]    k_q;
   logic              ready_q, ready_d;
   logic              ferr_q;
   logic              acc, start, load, drop;

   logic [PM_W-1:0]   pm_q   [64];
   logic [PM_W-1:0]   acs_pm [64];
   logic [63:0]       acs_dec;
   logic [63:0]       surv   [N_STEP];
   logic [63:0]       surv_row;
   logic [7:0]        obuf   [N_OUT];
   logic [N_OUT-1:0]  mark_q;

   function automatic logic [1:0] bm(input logic [5:0] p,
                                     input logic       u,
                                     input logic [1:0] r);
      logic v1, v2;
      v1 = u ^ p[3] ^ p[2] ^ p[1] ^ p[0];
      v2 = u ^ p[5] ^ p[3] ^ p[2] ^ p[0];
      return {1'b0, v1 ^ r[1]} + {1'b0, v2 ^ r[0]};
   endfunction

   // Add-compare-select for all 64 next states; ties go to predecessor 0.
   always_comb begin
      logic [5:0]      ns;
      logic [PM_W-1:0] c0, c1;
      ns      = '0;
      c0      = '0;
      c1      = '0;
      acs_dec = '0;
      for (int s = 0; s < 64; s++) begin
         ns = 6'(s);
         c0 = pm_q[{ns[4:0], 1'b0}]
            + PM_W'(bm({ns[4:0], 1'b0}, ns[5], sh_q[7:6]));
         c1 = pm_q[{ns[4:0], 1'b1}]
            + PM_W'(bm({ns[4:0], 1'b1}, ns[5], sh_q[7:6]));
         acs_dec[s] = c1 < c0;
         acs_pm[s]  = (c1 < c0) ? c1 : c0;
      end
   end

   assign acc      = s_axis_valid && ready_q;
   assign byte_idx = start ? '0 : byte_q;
   assign surv_row = surv[step_q];

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      load    = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (acc && s_axis_sop) begin
               start   = 1'b1;
               state_d = ST_ACS;
            end
         end
         ST_ACS: begin
            if (step_q == STEP_LAST)
               state_d = ST_TB;
            else if (pair_q == 2'd3)
               state_d = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            if (acc) begin
               if (s_axis_sop) begin
                  start   = 1'b1;
                  state_d = ST_ACS;
               end else if (s_axis_last != (byte_q == BYTE_LAST)) begin
                  drop    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  load    = 1'b1;
                  state_d = ST_ACS;
               end
            end
         end
         ST_TB: begin
            if (step_q == '0)
               state_d = ST_OUT;
         end
         ST_OUT: begin
            if (m_axis_ready && k_q == K_LAST)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCEPT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         byte_q  <= '0;
         pair_q  <= '0;
         tb_st_q <= '0;
         k_q     <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         ferr_q  <= drop;
         unique case (state_q)
            ST_IDLE, ST_ACCEPT: begin
               if (start) begin
                  step_q <= '0;
                  byte_q <= BYTE_W'(1);
                  pair_q <= '0;
               end else if (load) begin
                  byte_q <= byte_q + BYTE_W'(1);
                  pair_q <= '0;
               end
            end
            ST_ACS: begin
               pair_q <= pair_q + 2'd1;
               if (step_q == STEP_LAST) begin
                  tb_st_q <= '0;
                  k_q     <= '0;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end
            ST_TB: begin
               tb_st_q <= {tb_st_q[4:0], surv_row[tb_st_q]};
               step_q  <= step_q - STEP_W'(1);
            end
            ST_OUT: begin
               if (m_axis_ready)
                  k_q <= k_q + K_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Metrics, survivors and output bits are fully rewritten every block.
   always_ff @(posedge clk) begin
      if (start) begin
         for (int s = 0; s < 64; s++)
            pm_q[s] <= (s == 0) ? '0 : PM_INIT;
      end else if (state_q == ST_ACS) begin
         for (int s = 0; s < 64; s++)
            pm_q[s] <= acs_pm[s];
      end
      if (start || load)
         sh_q <= s_axis_data;
      else if (state_q == ST_ACS)
         sh_q <= {sh_q[5:0], 2'b00};
      if ((start || load) && !byte_idx[0]
          && byte_idx[BYTE_W-1:1] <= K_LAST)
         mark_q[byte_idx[BYTE_W-1:1]] <= s_axis_is_parity;
      if (state_q == ST_ACS)
         surv[step_q] <= acs_dec;
      if (state_q == ST_TB && step_q < BITS_END)
         obuf[step_q[STEP_W-1:3]][3'd7 - step_q[2:0]] <= tb_st_q[5];
   end

`ifdef CONV_VITERBI_METRIC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pm_final       <= '0;
         pm_final_valid <= 1'b0;
      end else begin
         pm_final_valid <= 1'b0;
         if (state_q == ST_ACS && step_q == STEP_LAST) begin
            pm_final       <= acs_pm[0];
            pm_final_valid <= 1'b1;
         end
      end
   end
`endif

   assign s_axis_ready     = ready_q;
   assign frame_err        = ferr_q;
   assign m_axis_valid     = (state_q == ST_OUT);
   assign m_axis_data      = m_axis_valid ? obuf[k_q] : '0;
   assign m_axis_sop       = m_axis_valid && (k_q == '0);
   assign m_axis_last      = m_axis_valid && (k_q == K_LAST);
   assign m_axis_is_parity = m_axis_valid && mark_q[k_q];

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// tb_conv_viterbi_decoder: scoreboard bench; encoder model feeds coded blocks,
// monitor compares every decoded byte against the queued source bytes.
module tb_conv_viterbi_decoder;

   localparam int N_OUT  = 255;
   localparam int N_BYTE = 512;
   localparam int PM_W   = 13;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            s_axis_valid = 1'b0;
   logic            s_axis_ready;
   logic [7:0]      s_axis_data = '0;
   logic            s_axis_last = 1'b0;
   logic            s_axis_sop = 1'b0;
   logic            s_axis_is_parity = 1'b0;
   logic            m_axis_valid;
   logic            m_axis_ready = 1'b1;
   logic [7:0]      m_axis_data;
   logic            m_axis_last;
   logic            m_axis_sop;
   logic            m_axis_is_parity;
`ifdef CONV_VITERBI_METRIC_EN
   logic [PM_W-1:0] pm_final;
   logic            pm_final_valid;
`endif
   logic            frame_err;

   conv_viterbi_decoder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_valid     (s_axis_valid),
      .s_axis_ready     (s_axis_ready),
      .s_axis_data      (s_axis_data),
      .s_axis_last      (s_axis_last),
      .s_axis_sop       (s_axis_sop),
      .s_axis_is_parity (s_axis_is_parity),
      .m_axis_valid     (m_axis_valid),
      .m_axis_ready     (m_axis_ready),
      .m_axis_data      (m_axis_data),
      .m_axis_last      (m_axis_last),
      .m_axis_sop       (m_axis_sop),
      .m_axis_is_parity (m_axis_is_parity),
`ifdef CONV_VITERBI_METRIC_EN
      .pm_final         (pm_final),
      .pm_final_valid   (pm_final_valid),
`endif
      .frame_err        (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       last;
      logic       par;
   } item_t;

   item_t      sb[$];
   int         checks = 0;
   int         errors = 0;
   int         duty = 100;
   int         gap_max = 0;
   int         fe_cnt = 0;
   int         valid_cnt = 0;
   int         out_idx = 0;
   logic [PM_W-1:0] pm_seen = '0;
   logic [7:0] dat    [N_OUT];
   logic       parv   [N_OUT];
   logic [7:0] coded  [N_BYTE];
   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic [7:0] pd = '0;

   always @(posedge clk) begin
      #1;
      m_axis_ready = ($urandom_range(0, 99) < duty);
   end

   always @(negedge clk) begin
      item_t e;
      if (rst_n) begin
         if (m_axis_valid) valid_cnt++;
         if (frame_err) fe_cnt++;
`ifdef CONV_VITERBI_METRIC_EN
         if (pm_final_valid) pm_seen = pm_final;
`endif
         if (pv && !pr) begin
            checks++;
            if (!m_axis_valid || m_axis_data !== pd) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h",
                        m_axis_valid, m_axis_data, pd);
            end
         end
         if (m_axis_valid && m_axis_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got data=%02h, want no output", m_axis_data);
            end else begin
               e = sb.pop_front();
               if ({m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity} !== e) begin
                  errors++;
                  $display("FAIL out_byte #%0d: got data=%02h sop=%0b last=%0b par=%0b, want data=%02h sop=%0b last=%0b par=%0b",
                           out_idx, m_axis_data, m_axis_sop, m_axis_last, m_axis_is_parity,
                           e.d, e.sop, e.last, e.par);
               end
            end
            out_idx++;
         end
         pv = m_axis_valid;
         pr = m_axis_ready;
         pd = m_axis_data;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic check_reset(input string name);
      chk({name, "_s_ready"}, 32'(s_axis_ready), 0);
      chk({name, "_m_valid"}, 32'(m_axis_valid), 0);
      chk({name, "_m_data"}, 32'(m_axis_data), 0);
      chk({name, "_m_sop"}, 32'(m_axis_sop), 0);
      chk({name, "_m_last"}, 32'(m_axis_last), 0);
      chk({name, "_m_par"}, 32'(m_axis_is_parity), 0);
      chk({name, "_frame_err"}, 32'(frame_err), 0);
`ifdef CONV_VITERBI_METRIC_EN
      chk({name, "_pm_final"}, 32'(pm_final), 0);
`endif
   endtask

   task automatic set_data(input int mode);
      for (int k = 0; k < N_OUT; k++) begin
         case (mode)
            0: begin dat[k] = (k == 0) ? 8'h80 : 8'h00; parv[k] = 1'b0; end
            1: begin dat[k] = 8'(k); parv[k] = (k >= 223); end
            2: begin dat[k] = 8'hA5 ^ 8'(k * 7); parv[k] = k[0]; end
            default: begin dat[k] = ~8'(k); parv[k] = (k >= 200); end
         endcase
      end
   endtask

   // Reference encoder: taps written as generator masks over {u, S[5:0]}.
   task automatic encode(input bit flips);
      logic [5:0] sr;
      logic [6:0] w;
      logic       u, v1, v2;
      sr = '0;
      for (int i = 0; i < N_BYTE; i++) coded[i] = '0;
      for (int i = 0; i < 2046; i++) begin
         u  = (i < 2040) ? dat[i / 8][7 - (i % 8)] : 1'b0;
         w  = {u, sr};
         v1 = ^(w & 7'b1001111);
         v2 = ^(w & 7'b1101101);
         if (flips && (i % 40) == 20) v1 = ~v1;
         coded[i / 4][7 - 2 * (i % 4) -: 2] = {v1, v2};
         sr = {u, sr[5:1]};
      end
   endtask

   task automatic send_block(input int nbytes, input int last_at, input bit expect_out);
      int  n;
      int  gap;
      bit  tmo;
      tmo = 1'b0;
      if (expect_out)
         for (int k = 0; k < N_OUT; k++)
            sb.push_back('{d: dat[k], sop: (k == 0), last: (k == N_OUT - 1), par: parv[k]});
      for (int i = 0; i < nbytes; i++) begin
         gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (gap) begin @(posedge clk); #1; end
         s_axis_valid     = 1'b1;
         s_axis_data      = coded[i];
         s_axis_sop       = (i == 0);
         s_axis_last      = (i == last_at);
         s_axis_is_parity = (i / 2 < N_OUT) ? parv[i / 2] : 1'b0;
         n = 0;
         forever begin
            @(negedge clk);
            if (s_axis_ready) break;
            n++;
            if (n > 20000) begin
               tmo = 1'b1;
               break;
            end
         end
         if (tmo) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: byte %0d not accepted within 20000 cycles", i);
            break;
         end
         @(posedge clk); #1;
         s_axis_valid = 1'b0;
         s_axis_sop   = 1'b0;
         s_axis_last  = 1'b0;
      end
      s_axis_valid = 1'b0;
      s_axis_sop   = 1'b0;
      s_axis_last  = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d bytes outstanding, want 0", name, sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int fe0, vc0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset_init");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      set_data(0);
      encode(1'b0);
      chk("model_coded0", 32'(coded[0]), 32'hD3);
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_impulse");
`ifdef CONV_VITERBI_METRIC_EN
      chk("pm_impulse", 32'(pm_seen), 0);
`endif

      set_data(1);
      encode(1'b0);
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_ramp");
`ifdef CONV_VITERBI_METRIC_EN
      chk("pm_ramp", 32'(pm_seen), 0);
`endif

      encode(1'b1);
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_flips");
`ifdef CONV_VITERBI_METRIC_EN
      chk("pm_flips", 32'(pm_seen), 51);
`endif

      encode(1'b0);
      duty    = 30;
      gap_max = 3;
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_stall");
      duty    = 100;
      gap_max = 0;

      set_data(2);
      encode(1'b0);
      fe0 = fe_cnt;
      vc0 = valid_cnt;
      send_block(301, 300, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      chk("early_last_frame_err", 32'(fe_cnt - fe0), 1);
      chk("early_last_no_valid", 32'(valid_cnt - vc0), 0);
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_after_drop");

      set_data(3);
      encode(1'b0);
      send_block(N_BYTE, N_BYTE - 1, 1'b0);
      repeat (1000) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_reset("reset_mid_tb");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      set_data(1);
      encode(1'b1);
      send_block(N_BYTE, N_BYTE - 1, 1'b1);
      drain("blk_after_reset");
`ifdef CONV_VITERBI_METRIC_EN
      chk("pm_after_reset", 32'(pm_seen), 51);
`endif
      chk("frame_err_total", 32'(fe_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_viterbi_decoder.md
Name: conv_viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the TX-chain convolutional code (K=7, rate 1/2, g1=171 oct, g2=133 oct); RX-side inverse of the encoder.
- Consumes 512-byte coded blocks: 2040 data pairs, 6 zero-tail pairs, 4 zero pad bits.
- Produces the 255-byte pre-encoding blocks. Uses full-block traceback from state 0, which the tail forces.

Parameters:
- PM_W, 13, path-metric width. Worst case is init 4095 plus 2046*2, which is below 8192, so no normalization is needed.
- N_OUT, 255, decoded bytes per block. Coded block is fixed at 2*N_OUT+2 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_valid  in  1  coded byte valid
- s_axis_ready  out  1  decoder can accept a coded byte
- s_axis_data  in  8  coded byte; pairs in bits [7:6],[5:4],[3:2],[1:0], first in time at [7:6]; pair bit order (v1,v2)
- s_axis_last  in  1  last coded byte (index 511)
- s_axis_sop  in  1  first coded byte (index 0)
- s_axis_is_parity  in  1  RS parity marker of the source byte
- m_axis_valid  out  1  decoded byte valid
- m_axis_ready  in  1  downstream ready
- m_axis_data  out  8  decoded byte, MSB first in time
- m_axis_last  out  1  on decoded byte N_OUT-1
- m_axis_sop  out  1  on decoded byte 0
- m_axis_is_parity  out  1  marker latched from coded byte 2k for decoded byte k
- frame_err  out  1  one-cycle pulse when a block is dropped

Behaviour:
- Reset values: s_axis_ready=0, all m_axis_* outputs=0, frame_err=0. Reset returns the FSM to ST_IDLE and discards any block in progress.
- State index S[5:0]:
  - S[5] is the newest input bit. Next state S'={u,S[5:1]}.
  - Expected outputs: v1=u^S[3]^S[2]^S[1]^S[0]; v2=u^S[5]^S[3]^S[2]^S[0].
- FSM states:
  - ST_IDLE: ready=1.
    - Accepting a byte with sop: PM[0]=0, PM[others]=4095, step counter=0, byte counter=0; go to ST_ACS.
    - A byte without sop is consumed and ignored.
  - ST_ACS: one trellis step per cycle, 4 cycles per byte, ready=0.
    - Branch metric = Hamming distance of the received pair to (v1,v2), range 0..2.
    - For each S', the candidates are predecessors {S'[4:0],0} and {S'[4:0],1}; the lower sum wins.
    - Tie-break: predecessor 0.
    - Decision bit d[S'] = the chosen predecessor's LSB. The 64 decisions are written to survivor memory row [step] (2046 x 64).
    - Byte 511: only pairs [7:6] and [5:4] are used; the pad nibble is ignored.
    - After step 2045, go to ST_TB. Otherwise go to ST_ACCEPT.
  - ST_ACCEPT: ready=1 and waits for the next byte.
    - sop: restart the block as in ST_IDLE.
    - last on a byte index other than 511: pulse frame_err, go to ST_IDLE.
    - Byte index 511 without last: frame_err, drop the block.
  - ST_TB: state=0, step=2045 down to 0, one step per cycle.
    - u=state[5]; state={state[4:0],d[step][state]}.
    - For step<2040, store u into the output bit buffer at position step. Tail steps are discarded.
    - 2046 cycles, ready=0.
  - ST_OUT: streams bytes k=0..N_OUT-1. data = bits 8k..8k+7, bit 8k in data[7].
    - sop on k=0, last on k=N_OUT-1, is_parity=marker[k].
    - Holds while valid && !ready; advances on valid && ready. After the last byte, go to ST_IDLE.
- Latency: from acceptance of coded byte 511 to the first output byte = 2 ACS cycles + 2046 TB cycles + 1.
- While the block decodes and streams out, s_axis_ready stays 0; no block overlap.

Optional Feature:
- CONV_VITERBI_METRIC_EN:
  - Defined: adds output port pm_final [PM_W-1:0] (reset 0) and pm_final_valid [1] (pulse).
  - At entry to ST_TB they latch and pulse PM[0], i.e. the count of corrected channel bit errors on the decided path.
- Undefined: ports and logic are absent; otherwise behaviour is identical.

Test Plan:
- Error-free block, data 0x80 then 254 x 0x00. First coded byte is 0xD3; model-encoded 512 bytes are fed -> output equals input bytes, sop on byte 0, last on byte 254, pm_final=0.
- Data 0x00..0xFE, bytes 0..222 marked non-parity and 223..254 parity -> exact bytes returned; is_parity=1 exactly on k=223..254.
- Same block with one flipped coded bit every 40 pairs (51 flips) -> output is error-free; pm_final=51.
- Random s_axis_valid gaps and m_axis_ready at 30% duty -> identical output; m_axis_data stable while stalled.
- last asserted on coded byte 300 -> frame_err pulses once; no m_axis_valid; next full block decodes correctly.
- rst_n asserted mid-ST_TB, then a fresh block -> outputs at reset values during reset; the fresh block decodes correctly.
